uart_rx: RTL



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, oversample default,
// parity-sense constants and the frame-format bundle used by TX and RX.
package uart_pkg;

  localparam int UART_RX_OVERSAMPLE_DEFAULT = 16;

  localparam logic [2:0] RX_ST_IDLE   = 3'd0;
  localparam logic [2:0] RX_ST_START  = 3'd1;
  localparam logic [2:0] RX_ST_DATA   = 3'd2;
  localparam logic [2:0] RX_ST_PARITY = 3'd3;
  localparam logic [2:0] RX_ST_STOP   = 3'd4;

  localparam logic PARITY_ODD  = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  typedef struct packed {
    logic eight_bits;
    logic parity_en;
    logic parity_sense;
  } uart_fmt_t;

  // Parity bit a transmitter of this format appends after the data bits
  function automatic logic parity_bit(input logic [7:0] data, input logic sense);
    logic p;
    if (sense == PARITY_EVEN) begin
      p = ^data;
    end else if (sense == PARITY_ODD) begin
      p = ~^data;
    end else begin
      p = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer: two flops into the PCLK domain plus a history
// flop for falling-edge detection; all flops reset to the idle-high level.
module uart_rx_sync (
  input  logic PCLK,
  input  logic PRESET,
  input  logic line_async,
  output logic line_sync,
  output logic line_fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and previous-value history
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= line_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign line_sync = sync_r;
  assign line_fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 7/8-bit frames, optional parity, one-deep holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 mid-bit voting instead of a single sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_RX_OVERSAMPLE = UART_RX_OVERSAMPLE_DEFAULT
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       rx_sample_pulse,
  input  logic       UART_RX,
  input  logic       data_bits,
  input  logic       parity_en,
  input  logic       parity_odd0_even1,
  input  logic       rx_data_reg_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam logic [3:0] OS_LAST = 4'(UART_RX_OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID  = 4'(UART_RX_OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] OS_DECIDE = OS_MID + 4'd1;
`else
  localparam logic [3:0] OS_DECIDE = OS_MID;
`endif

  logic       line_s;
  logic       fall_s;
  logic       bit_s;
  logic       decide_s;
  logic       rd_s;
  logic [3:0] os_next_s;
  logic [2:0] last_bit_s;

  logic [2:0] state_r;
  logic [3:0] os_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  uart_fmt_t  fmt_r;
  logic       par_mismatch_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       parity_err_r;
  logic       frame_err_r;
  logic       overrun_err_r;

  uart_rx_sync u_sync (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .line_async (UART_RX),
    .line_sync  (line_s),
    .line_fall  (fall_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_early_r;
  logic vote_mid_r;

  // Samples one pulse before and at mid-bit; the third vote is the live line
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      vote_early_r <= 1'b1;
      vote_mid_r   <= 1'b1;
    end else if (rx_sample_pulse && (os_cnt_r == (OS_MID - 4'd1))) begin
      vote_early_r <= line_s;
    end else if (rx_sample_pulse && (os_cnt_r == OS_MID)) begin
      vote_mid_r <= line_s;
    end else begin
      vote_early_r <= vote_early_r;
      vote_mid_r   <= vote_mid_r;
    end
  end

  assign bit_s = (vote_early_r & vote_mid_r) | (vote_early_r & line_s) | (vote_mid_r & line_s);
`else
  assign bit_s = line_s;
`endif

  assign decide_s   = rx_sample_pulse & (os_cnt_r == OS_DECIDE);
  assign os_next_s  = (os_cnt_r == OS_LAST) ? 4'd0 : (os_cnt_r + 4'd1);
  assign last_bit_s = fmt_r.eight_bits ? 3'd7 : 3'd6;
  assign rd_s       = rx_data_reg_rd & rx_valid_r;

  // Frame FSM and holding register; a stop write in the same cycle as a read wins
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r             <= RX_ST_IDLE;
      os_cnt_r            <= 4'd0;
      bit_cnt_r           <= 3'd0;
      shift_r             <= 8'h00;
      fmt_r.eight_bits    <= 1'b0;
      fmt_r.parity_en     <= 1'b0;
      fmt_r.parity_sense  <= 1'b0;
      par_mismatch_r      <= 1'b0;
      rx_data_r           <= 8'h00;
      rx_valid_r          <= 1'b0;
      parity_err_r        <= 1'b0;
      frame_err_r         <= 1'b0;
      overrun_err_r       <= 1'b0;
    end else begin
      if (rd_s) begin
        rx_valid_r    <= 1'b0;
        overrun_err_r <= 1'b0;
      end
      case (state_r)
        RX_ST_IDLE: begin
          if (fall_s) begin
            state_r  <= RX_ST_START;
            os_cnt_r <= 4'd0;
          end
        end
        RX_ST_START: begin
          if (rx_sample_pulse) begin
            os_cnt_r <= os_next_s;
          end
          if (decide_s) begin
            if (bit_s) begin
              state_r <= RX_ST_IDLE;
            end else begin
              state_r            <= RX_ST_DATA;
              fmt_r.eight_bits   <= data_bits;
              fmt_r.parity_en    <= parity_en;
              fmt_r.parity_sense <= parity_odd0_even1;
              shift_r            <= 8'h00;
              bit_cnt_r          <= 3'd0;
              par_mismatch_r     <= 1'b0;
            end
          end
        end
        RX_ST_DATA: begin
          if (rx_sample_pulse) begin
            os_cnt_r <= os_next_s;
          end
          if (decide_s) begin
            shift_r[bit_cnt_r] <= bit_s;
            if (bit_cnt_r == last_bit_s) begin
              bit_cnt_r <= 3'd0;
              state_r   <= fmt_r.parity_en ? RX_ST_PARITY : RX_ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        RX_ST_PARITY: begin
          if (rx_sample_pulse) begin
            os_cnt_r <= os_next_s;
          end
          if (decide_s) begin
            par_mismatch_r <= bit_s ^ parity_bit(shift_r, fmt_r.parity_sense);
            state_r        <= RX_ST_STOP;
          end
        end
        RX_ST_STOP: begin
          if (decide_s) begin
            rx_data_r    <= shift_r;
            parity_err_r <= fmt_r.parity_en & par_mismatch_r;
            frame_err_r  <= ~bit_s;
            rx_valid_r   <= 1'b1;
            if (rx_valid_r && !rx_data_reg_rd) begin
              overrun_err_r <= 1'b1;
            end
            os_cnt_r <= 4'd0;
            state_r  <= RX_ST_IDLE;
          end else if (rx_sample_pulse) begin
            os_cnt_r <= os_next_s;
          end
        end
        default: begin
          state_r <= RX_ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign parity_err  = parity_err_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;
  assign rx_busy     = (state_r != RX_ST_IDLE);

endmodule
